// File: rtl/counter_ctrl_pkg.sv
// Shared types and helpers for the button command controller.
// Holds the FSM state encoding, request bit positions and priority arbitration.
package counter_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    ISSUE    = 3'd2,
    HOLD     = 3'd3
  } ctrl_state_t;

  localparam int REQ_UP   = 0;
  localparam int REQ_DOWN = 1;
  localparam int REQ_CLR  = 2;

  // Fixed priority: clear beats up, up beats down; result is one-hot or zero.
  function automatic logic [2:0] pick_winner(input logic [2:0] req);
    logic [2:0] win;
    win = 3'b000;
    if (req[REQ_CLR]) begin
      win[REQ_CLR] = 1'b1;
    end else if (req[REQ_UP]) begin
      win[REQ_UP] = 1'b1;
    end else if (req[REQ_DOWN]) begin
      win[REQ_DOWN] = 1'b1;
    end else begin
      win = 3'b000;
    end
    return win;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/counter_ctrl_sync.sv
// Parameterised two-flop synchroniser for asynchronous button inputs.
// Synchronous active-low reset clears both stages.
module btn_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture of the raw inputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/counter_ctrl.sv
// Button command controller: synchronises, debounces and arbitrates up/down/clear
// presses into single-cycle counter commands. Define AUTO_REPEAT_EN for hold-to-repeat.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_250_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] btn_req,
  output logic       cnt_en,
  output logic       cnt_up,
  output logic       cnt_clr,
  output logic [2:0] grant,
  output logic       busy,
  output logic [2:0] debug_state
);

  localparam int TMAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [TW-1:0] DB_LOAD = TW'(DEBOUNCE_CYCLES - 1);

`ifdef AUTO_REPEAT_EN
  // Repeat timer is loaded one cycle late (while in ISSUE) so it is offset by two.
  localparam int RPT_DELAY_I  = (REPEAT_DELAY  > 1) ? REPEAT_DELAY  - 2 : 0;
  localparam int RPT_PERIOD_I = (REPEAT_PERIOD > 1) ? REPEAT_PERIOD - 2 : 0;
  localparam logic [TW-1:0] RPT_DELAY_LOAD  = TW'(RPT_DELAY_I);
  localparam logic [TW-1:0] RPT_PERIOD_LOAD = TW'(RPT_PERIOD_I);
`endif

  logic [2:0]  req_sync;
  logic        granted_hi;

  ctrl_state_t state_q,   state_d;
  logic [2:0]  grant_q,   grant_d;
  logic [TW-1:0] timer_q, timer_d;
  logic        cnt_en_q,  cnt_en_d;
  logic        cnt_up_q,  cnt_up_d;
  logic        cnt_clr_q, cnt_clr_d;
  logic        busy_q,    busy_d;
`ifdef AUTO_REPEAT_EN
  logic [TW-1:0] rpt_q,   rpt_d;
`endif

  btn_sync #(
    .WIDTH(3)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_req),
    .q     (req_sync)
  );

  assign granted_hi = |(req_sync & grant_q);

  // Next-state, timer and registered-output decode.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    timer_d = timer_q;
`ifdef AUTO_REPEAT_EN
    rpt_d   = rpt_q;
`endif

    case (state_q)
      IDLE: begin
        if (|req_sync) begin
          grant_d = pick_winner(req_sync);
          timer_d = DB_LOAD;
          state_d = DEBOUNCE;
        end else begin
          grant_d = 3'b000;
        end
      end
      DEBOUNCE: begin
        if (!granted_hi) begin
          state_d = IDLE;
          grant_d = 3'b000;
        end else if (timer_q == '0) begin
          state_d = ISSUE;
`ifdef AUTO_REPEAT_EN
          rpt_d   = RPT_DELAY_LOAD;
`endif
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      ISSUE: begin
        state_d = HOLD;
        timer_d = DB_LOAD;
      end
      HOLD: begin
`ifdef AUTO_REPEAT_EN
        if (rpt_q != '0) begin
          rpt_d = rpt_q - T_ONE;
        end else begin
          rpt_d = rpt_q;
        end
`endif
        if (granted_hi) begin
          timer_d = DB_LOAD;
`ifdef AUTO_REPEAT_EN
          // Clear never repeats; up/down re-issue once the repeat timer runs out.
          if (!grant_q[REQ_CLR] && (rpt_q == '0)) begin
            state_d = ISSUE;
            rpt_d   = RPT_PERIOD_LOAD;
          end else begin
            state_d = HOLD;
          end
`endif
        end else if (timer_q == '0) begin
          state_d = IDLE;
          grant_d = 3'b000;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 3'b000;
        timer_d = '0;
      end
    endcase

    cnt_en_d  = (state_d == ISSUE) && !grant_d[REQ_CLR];
    cnt_clr_d = (state_d == ISSUE) &&  grant_d[REQ_CLR];
    cnt_up_d  = cnt_en_d && grant_d[REQ_UP];
    busy_d    = (state_d != IDLE);
  end

  // State, timers and outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant_q   <= 3'b000;
      timer_q   <= '0;
      cnt_en_q  <= 1'b0;
      cnt_up_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      timer_q   <= timer_d;
      cnt_en_q  <= cnt_en_d;
      cnt_up_q  <= cnt_up_d;
      cnt_clr_q <= cnt_clr_d;
      busy_q    <= busy_d;
`ifdef AUTO_REPEAT_EN
      rpt_q     <= rpt_d;
`endif
    end
  end

  assign cnt_en      = cnt_en_q;
  assign cnt_up      = cnt_up_q;
  assign cnt_clr     = cnt_clr_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign debug_state = state_q;

endmodule
